// File: rtl/dbus_mem_responder_if.sv
// MEM-stage data-bus bundle (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n), ERR only with DBUS_ALIGN_CHK_EN.
// DDT is resolved here from the master and slave drive/enable pairs; it floats when neither side drives.
interface dbus_mem_responder_if;
    logic [31:0] DAD;
    logic        MREQ;
    logic        WRITE;
    logic [1:0]  SIZE;
    logic        ACKD_n;
`ifdef DBUS_ALIGN_CHK_EN
    logic        ERR;
`endif
    logic [31:0] ddt_mst;
    logic        ddt_mst_oe;
    logic [31:0] ddt_slv;
    logic        ddt_slv_oe;
    wire  [31:0] DDT;

    // Shared data bus: slave wins only while acknowledging a read
    assign DDT = (ddt_slv_oe || ddt_mst_oe) ? (ddt_slv_oe ? ddt_slv : ddt_mst) : 32'bz;

    modport slave (
        input  DAD, MREQ, WRITE, SIZE, DDT,
        output ACKD_n, ddt_slv, ddt_slv_oe
`ifdef DBUS_ALIGN_CHK_EN
        , output ERR
`endif
    );

    modport master (
        output DAD, MREQ, WRITE, SIZE, ddt_mst, ddt_mst_oe,
        input  ACKD_n, DDT
`ifdef DBUS_ALIGN_CHK_EN
        , input ERR
`endif
    );
endinterface

// File: rtl/dbus_mem_responder.sv
// Data-bus slave: word-organised big-endian RAM, programmable wait states, one-cycle ACKD_n.
// `define DBUS_ALIGN_CHK_EN adds misalignment detection and the ERR flag; otherwise low address bits are ignored.
module dbus_mem_responder #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned WAIT_CYC = 1
) (
    input logic                 CLOCK,
    input logic                 RESET,
    dbus_mem_responder_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;

    logic [ADDR_W-1:0] lat_addr;
    logic [1:0]        lat_off;
    logic              lat_write;
    logic [1:0]        lat_size;
    logic [31:0]       lat_data;

    logic [ADDR_W-1:0] acc_addr_c;
    logic [1:0]        acc_off_c;
    logic              acc_write_c;
    logic [1:0]        acc_size_c;
    logic [31:0]       acc_data_c;

    logic              go_ack_c;
    logic              mis_c;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c;
    logic [31:0]       rdata_c;
    logic [31:0]       word_c;
    logic              unused_dad_c;

    logic [31:0]       mem [DEPTH];

    // Zero-wait accesses complete straight from IDLE, so use the live bus there
    assign acc_addr_c  = (state == ST_IDLE) ? bus.DAD[ADDR_W+1:2] : lat_addr;
    assign acc_off_c   = (state == ST_IDLE) ? bus.DAD[1:0]        : lat_off;
    assign acc_write_c = (state == ST_IDLE) ? bus.WRITE           : lat_write;
    assign acc_size_c  = (state == ST_IDLE) ? bus.SIZE            : lat_size;
    assign acc_data_c  = (state == ST_IDLE) ? bus.DDT             : lat_data;

    assign go_ack_c     = (state_nxt == ST_ACK);
    assign word_c       = mem[acc_addr_c];
    assign unused_dad_c = ^bus.DAD[31:ADDR_W+2];

`ifdef DBUS_ALIGN_CHK_EN
    assign mis_c = ((acc_size_c == 2'b01) && acc_off_c[0]) ||
                   (((acc_size_c == 2'b00) || (acc_size_c == 2'b11)) && (acc_off_c != 2'b00));
`else
    assign mis_c = 1'b0;
`endif

    // State register
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and wait counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (bus.MREQ) begin
                    if (WAIT_CYC == 0) begin
                        state_nxt = ST_ACK;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_W'(WAIT_CYC);
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.MREQ) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt <= CNT_W'(1)) state_nxt = ST_ACK;
                end
            end
            ST_ACK:  state_nxt = ST_DONE;
            ST_DONE: if (!bus.MREQ) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Big-endian lane steering: offset 0 is the most significant byte
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = acc_data_c;
        rdata_c = word_c;
        unique case (acc_size_c)
            2'b01: begin
                be_c    = acc_off_c[1] ? 4'b0011 : 4'b1100;
                wdata_c = {2{acc_data_c[15:0]}};
                rdata_c = {16'h0, acc_off_c[1] ? word_c[15:0] : word_c[31:16]};
            end
            2'b10: begin
                be_c    = 4'b1000 >> acc_off_c;
                wdata_c = {4{acc_data_c[7:0]}};
                unique case (acc_off_c)
                    2'd0:    rdata_c = {24'h0, word_c[31:24]};
                    2'd1:    rdata_c = {24'h0, word_c[23:16]};
                    2'd2:    rdata_c = {24'h0, word_c[15:8]};
                    default: rdata_c = {24'h0, word_c[7:0]};
                endcase
            end
            default: ;
        endcase
        if (mis_c || !acc_write_c) be_c = 4'b0000;
        if (mis_c) rdata_c = '0;
    end

    // RAM is never cleared; a write held off by reset is simply lost
    always_ff @(posedge CLOCK) begin
        if (go_ack_c && !RESET) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) mem[acc_addr_c][8*b +: 8] <= wdata_c[8*b +: 8];
            end
        end
    end

    // Request capture and registered bus outputs
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            lat_addr       <= '0;
            lat_off        <= '0;
            lat_write      <= 1'b0;
            lat_size       <= '0;
            lat_data       <= '0;
            bus.ACKD_n     <= 1'b1;
            bus.ddt_slv    <= '0;
            bus.ddt_slv_oe <= 1'b0;
`ifdef DBUS_ALIGN_CHK_EN
            bus.ERR        <= 1'b0;
`endif
        end else begin
            if ((state == ST_IDLE) && bus.MREQ) begin
                lat_addr  <= bus.DAD[ADDR_W+1:2];
                lat_off   <= bus.DAD[1:0];
                lat_write <= bus.WRITE;
                lat_size  <= bus.SIZE;
                lat_data  <= bus.DDT;
            end
            bus.ACKD_n     <= !go_ack_c;
            bus.ddt_slv_oe <= go_ack_c && !acc_write_c;
            if (go_ack_c) bus.ddt_slv <= rdata_c;
`ifdef DBUS_ALIGN_CHK_EN
            bus.ERR        <= go_ack_c && mis_c;
`endif
        end
    end
endmodule

// File: tb/tb_dbus_mem_responder.sv
// Randomised self-checking bench for dbus_mem_responder: three instances (WAIT_CYC 0/1/3) against a byte-level model.
`timescale 1ns/1ps
module tb_dbus_mem_responder;
    localparam int N_DUT  = 3;
    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] dad  [N_DUT];
    logic        mreq [N_DUT];
    logic        wr   [N_DUT];
    logic [1:0]  sz   [N_DUT];
    logic [31:0] mdat [N_DUT];
    logic        moe  [N_DUT];
    logic        ackn [N_DUT];
    logic [31:0] ddt_obs [N_DUT];
    logic        soe  [N_DUT];
    logic        err  [N_DUT];

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        dbus_mem_responder_if bus ();
        assign bus.DAD        = dad[g];
        assign bus.MREQ       = mreq[g];
        assign bus.WRITE      = wr[g];
        assign bus.SIZE       = sz[g];
        assign bus.ddt_mst    = mdat[g];
        assign bus.ddt_mst_oe = moe[g];
        assign ackn[g]        = bus.ACKD_n;
        assign ddt_obs[g]     = bus.DDT;
        assign soe[g]         = bus.ddt_slv_oe;
`ifdef DBUS_ALIGN_CHK_EN
        assign err[g]         = bus.ERR;
`else
        assign err[g]         = 1'b0;
`endif
        dbus_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYC(g == 0 ? 0 : (g == 1 ? 1 : 3))) u_dut (
            .CLOCK (clk),
            .RESET (rst),
            .bus   (bus)
        );
    end

    int vectors    = 0;
    int miscompares = 0;

    // Results of the last bus_access
    int          r_lat;
    logic [31:0] r_rd;
    logic        r_oe, r_err, r_ack2, r_oe2;

    // Reference memory: byte addressed, big-endian, 4 KiB alias window
    logic [7:0] mref [N_DUT][4096];

    function automatic int wc(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    function automatic bit misaligned(input logic [31:0] a, input logic [1:0] s);
`ifdef DBUS_ALIGN_CHK_EN
        return ((s == 2'b01) && a[0]) || (((s == 2'b00) || (s == 2'b11)) && (a[1:0] != 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b10) ? 1 : ((s == 2'b01) ? 2 : 4);
    endfunction

    function automatic void model_write(input int d, input logic [31:0] a, input logic [1:0] s, input logic [31:0] v);
        int n    = nbytes(s);
        int base = int'(a[11:0]) & ~(n - 1);
        if (misaligned(a, s)) return;
        for (int i = 0; i < n; i++) mref[d][base + i] = v[8*(n-1-i) +: 8];
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [31:0] a, input logic [1:0] s);
        int n    = nbytes(s);
        int base = int'(a[11:0]) & ~(n - 1);
        logic [31:0] r = '0;
        if (misaligned(a, s)) return '0;
        for (int i = 0; i < n; i++) r = (r << 8) | {24'h0, mref[d][base + i]};
        return r;
    endfunction

    // One complete master transaction with a bounded wait for ACKD_n
    task automatic bus_access(input int d, input logic [31:0] a, input logic w, input logic [1:0] s, input logic [31:0] v);
        @(negedge clk);
        dad[d] = a; wr[d] = w; sz[d] = s; mdat[d] = v; moe[d] = w; mreq[d] = 1'b1;
        if (w) model_write(d, a, s, v);
        r_lat = -1; r_rd = '0; r_oe = 1'b0; r_err = 1'b0; r_ack2 = 1'b0; r_oe2 = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (ackn[d] === 1'b0) begin
                r_lat = c; r_rd = ddt_obs[d]; r_oe = soe[d]; r_err = err[d];
                break;
            end
        end
        if (r_lat > 0) begin
            @(posedge clk); #1;
            r_ack2 = ackn[d]; r_oe2 = soe[d];
        end
        @(negedge clk);
        mreq[d] = 1'b0; moe[d] = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < N_DUT; d++) begin
            dad[d] = '0; mreq[d] = 1'b0; wr[d] = 1'b0; sz[d] = '0; mdat[d] = '0; moe[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < N_DUT; d++) begin
            vectors++; if (ackn[d] !== 1'b1) begin miscompares++; $display("FAIL reset_ackn[%0d]: got %b want 1", d, ackn[d]); end
            vectors++; if (soe[d] !== 1'b0) begin miscompares++; $display("FAIL reset_ddt_drive[%0d]: got %b want 0", d, soe[d]); end
`ifdef DBUS_ALIGN_CHK_EN
            vectors++; if (err[d] !== 1'b0) begin miscompares++; $display("FAIL reset_err[%0d]: got %b want 0", d, err[d]); end
`endif
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word_rw();
        bus_access(1, 32'h10, 1'b1, 2'b00, 32'hDEADBEEF);
        vectors++; if (r_lat !== 2) begin miscompares++; $display("FAIL word_wr_latency: got %0d want 2", r_lat); end
        vectors++; if (r_ack2 !== 1'b1) begin miscompares++; $display("FAIL word_wr_ack_width: got %b want 1", r_ack2); end
        vectors++; if (r_oe !== 1'b0) begin miscompares++; $display("FAIL word_wr_ddt_drive: got %b want 0", r_oe); end
        bus_access(1, 32'h10, 1'b0, 2'b00, 32'h0);
        vectors++; if (r_lat !== 2) begin miscompares++; $display("FAIL word_rd_latency: got %0d want 2", r_lat); end
        vectors++; if (r_rd !== model_read(1, 32'h10, 2'b00)) begin miscompares++; $display("FAIL word_rd_data: got %h want %h", r_rd, model_read(1, 32'h10, 2'b00)); end
        vectors++; if (r_oe !== 1'b1) begin miscompares++; $display("FAIL word_rd_ddt_drive: got %b want 1", r_oe); end
        vectors++; if (r_ack2 !== 1'b1) begin miscompares++; $display("FAIL word_rd_ack_width: got %b want 1", r_ack2); end
        vectors++; if (r_oe2 !== 1'b0) begin miscompares++; $display("FAIL word_rd_ddt_release: got %b want 0", r_oe2); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] exp;
        for (int i = 0; i < 4; i++) bus_access(1, 32'h20 + 32'(i), 1'b1, 2'b10, 32'(8'h11 * (i + 1)));
        bus_access(1, 32'h20, 1'b0, 2'b00, 32'h0);
        exp = model_read(1, 32'h20, 2'b00);
        vectors++; if (r_rd !== exp) begin miscompares++; $display("FAIL lane_word_rd: got %h want %h", r_rd, exp); end
        bus_access(1, 32'h22, 1'b0, 2'b01, 32'h0);
        exp = model_read(1, 32'h22, 2'b01);
        vectors++; if (r_rd !== exp) begin miscompares++; $display("FAIL lane_half_rd: got %h want %h", r_rd, exp); end
        bus_access(1, 32'h21, 1'b0, 2'b10, 32'h0);
        exp = model_read(1, 32'h21, 2'b10);
        vectors++; if (r_rd !== exp) begin miscompares++; $display("FAIL lane_byte_rd: got %h want %h", r_rd, exp); end
    endtask

    task automatic test_held_mreq();
        int n_ack = 0;
        int first = 0;
        logic [31:0] rd = '0;
        logic [31:0] exp;
        bus_access(0, 32'h10, 1'b1, 2'b00, 32'hCAFEF00D);
        vectors++; if (r_lat !== 1) begin miscompares++; $display("FAIL held_wr_latency: got %0d want 1", r_lat); end
        exp = model_read(0, 32'h10, 2'b00);
        @(negedge clk);
        dad[0] = 32'h10; wr[0] = 1'b0; sz[0] = 2'b00; mreq[0] = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (ackn[0] === 1'b0) begin
                n_ack++;
                if (first == 0) begin first = c; rd = ddt_obs[0]; end
            end
        end
        vectors++; if (n_ack !== 1) begin miscompares++; $display("FAIL held_ack_count: got %0d want 1", n_ack); end
        vectors++; if (first !== 1) begin miscompares++; $display("FAIL held_ack_cycle: got %0d want 1", first); end
        vectors++; if (rd !== exp) begin miscompares++; $display("FAIL held_rd_data: got %h want %h", rd, exp); end
        @(negedge clk); mreq[0] = 1'b0;
        @(posedge clk); #1;
        vectors++; if (ackn[0] !== 1'b1) begin miscompares++; $display("FAIL held_gap_ack: got %b want 1", ackn[0]); end
        @(negedge clk); mreq[0] = 1'b1;
        @(posedge clk); #1;
        vectors++; if (ackn[0] !== 1'b0) begin miscompares++; $display("FAIL held_reserve_ack: got %b want 0", ackn[0]); end
        @(negedge clk); mreq[0] = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_abort();
        int n_ack = 0;
        logic [31:0] exp;
        bus_access(2, 32'h30, 1'b1, 2'b00, 32'h0);
        vectors++; if (r_lat !== 4) begin miscompares++; $display("FAIL abort_setup_latency: got %0d want 4", r_lat); end
        @(negedge clk);
        dad[2] = 32'h30; wr[2] = 1'b1; sz[2] = 2'b00; mdat[2] = 32'h12345678; moe[2] = 1'b1; mreq[2] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); mreq[2] = 1'b0; moe[2] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ackn[2] === 1'b0) n_ack++;
        end
        vectors++; if (n_ack !== 0) begin miscompares++; $display("FAIL abort_ack_count: got %0d want 0", n_ack); end
        bus_access(2, 32'h30, 1'b0, 2'b00, 32'h0);
        exp = model_read(2, 32'h30, 2'b00);
        vectors++; if (r_rd !== exp) begin miscompares++; $display("FAIL abort_rd_data: got %h want %h", r_rd, exp); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        dad[1] = 32'h10; wr[1] = 1'b0; sz[1] = 2'b00; mreq[1] = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b1; mreq[1] = 1'b0;
        #1;
        vectors++; if (ackn[1] !== 1'b1) begin miscompares++; $display("FAIL rst_wait_ackn: got %b want 1", ackn[1]); end
        vectors++; if (soe[1] !== 1'b0) begin miscompares++; $display("FAIL rst_wait_ddt: got %b want 0", soe[1]); end
        @(posedge clk); #1;
        vectors++; if (ackn[1] !== 1'b1) begin miscompares++; $display("FAIL rst_wait_no_ack: got %b want 1", ackn[1]); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); mreq[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (soe[1] !== 1'b1) begin miscompares++; $display("FAIL rst_ack_pre_ddt: got %b want 1", soe[1]); end
        rst = 1'b1;
        #1;
        vectors++; if (ackn[1] !== 1'b1) begin miscompares++; $display("FAIL rst_ack_ackn: got %b want 1", ackn[1]); end
        vectors++; if (soe[1] !== 1'b0) begin miscompares++; $display("FAIL rst_ack_ddt: got %b want 0", soe[1]); end
        @(negedge clk); mreq[1] = 1'b0; rst = 1'b0;
        bus_access(1, 32'h10, 1'b0, 2'b00, 32'h0);
        vectors++; if (r_lat !== 2) begin miscompares++; $display("FAIL rst_fresh_latency: got %0d want 2", r_lat); end
        vectors++; if (r_rd !== model_read(1, 32'h10, 2'b00)) begin miscompares++; $display("FAIL rst_fresh_data: got %h want %h", r_rd, model_read(1, 32'h10, 2'b00)); end
    endtask

    task automatic test_align();
        logic [31:0] exp;
        bus_access(1, 32'h40, 1'b1, 2'b00, 32'hA5A5A5A5);
        bus_access(1, 32'h41, 1'b1, 2'b01, 32'h0000BEEF);
        vectors++; if (r_lat !== 2) begin miscompares++; $display("FAIL align_wr_latency: got %0d want 2", r_lat); end
`ifdef DBUS_ALIGN_CHK_EN
        vectors++; if (r_err !== 1'b1) begin miscompares++; $display("FAIL align_wr_err: got %b want 1", r_err); end
`endif
        bus_access(1, 32'h40, 1'b0, 2'b00, 32'h0);
        exp = model_read(1, 32'h40, 2'b00);
        vectors++; if (r_rd !== exp) begin miscompares++; $display("FAIL align_word40: got %h want %h", r_rd, exp); end
`ifdef DBUS_ALIGN_CHK_EN
        vectors++; if (r_err !== 1'b0) begin miscompares++; $display("FAIL align_ok_err: got %b want 0", r_err); end
`endif
        bus_access(1, 32'h42, 1'b0, 2'b00, 32'h0);
        exp = model_read(1, 32'h42, 2'b00);
        vectors++; if (r_rd !== exp) begin miscompares++; $display("FAIL align_word42: got %h want %h", r_rd, exp); end
`ifdef DBUS_ALIGN_CHK_EN
        vectors++; if (r_err !== 1'b1) begin miscompares++; $display("FAIL align_rd_err: got %b want 1", r_err); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] a, v, exp;
        logic [1:0]  s;
        logic        w;
        int          d;
        for (int dd = 0; dd < N_DUT; dd++) begin
            for (int i = 0; i < 16; i++) bus_access(dd, ($urandom() & 32'hFFFF_F000) | (32'h100 + 32'(4 * i)), 1'b1, 2'b00, $urandom());
        end
        for (int n = 0; n < 60; n++) begin
            d   = int'($urandom_range(0, N_DUT - 1));
            a   = ($urandom() & 32'hFFFF_F000) | 32'h100 | 32'($urandom_range(0, 63));
            s   = 2'($urandom_range(0, 3));
            w   = 1'($urandom_range(0, 1));
            v   = $urandom();
            exp = model_read(d, a, s);
            bus_access(d, a, w, s, v);
            vectors++; if (r_lat !== wc(d) + 1) begin miscompares++; $display("FAIL rnd_latency[%0d] dut%0d a=%h: got %0d want %0d", n, d, a, r_lat, wc(d) + 1); end
            if (!w) begin
                vectors++; if (r_rd !== exp) begin miscompares++; $display("FAIL rnd_rd[%0d] dut%0d a=%h s=%0d: got %h want %h", n, d, a, s, r_rd, exp); end
            end
`ifdef DBUS_ALIGN_CHK_EN
            vectors++; if (r_err !== misaligned(a, s)) begin miscompares++; $display("FAIL rnd_err[%0d] a=%h s=%0d: got %b want %b", n, a, s, r_err, misaligned(a, s)); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_held_mreq();
        test_abort();
        test_reset_mid();
        test_align();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dbus_mem_responder.md
Name: dbus_mem_responder

Overview:
- Data-bus slave on the far end of the processor MEM-stage bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).
- Accepts word, halfword and byte reads/writes into an internal word-organised RAM.
- Inserts programmable wait states and acknowledges each access with a one-cycle active-low ACKD_n.
- Drives the shared DDT bus only while acknowledging a read.

Parameters:
- ADDR_W, 10, word-address bits; RAM depth 2^ADDR_W words (4 KiB default). DAD[ADDR_W+1:2] selects the word; upper DAD bits are ignored (aliasing).
- WAIT_CYC, 1, wait cycles between request acceptance and ACK (0..15).

Ports:
- CLOCK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- DAD  in  32  byte address from master
- DDT  inout  32  data; master drives on writes, block drives on read ACK only, else high-Z
- MREQ  in  1  request, active high; held with DAD/WRITE/SIZE/DDT stable until ACK seen
- WRITE  in  1  1 = write, 0 = read
- SIZE  in  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as word)
- ACKD_n  out  1  acknowledge, active low, one cycle per access
- ERR  out  1  misalignment flag; present only with DBUS_ALIGN_CHK_EN

Behaviour:
- Reset (async, active-high): state IDLE, ACKD_n=1, DDT high-Z, wait counter=0, ERR=0. RAM contents are not cleared.
- Clock and reset: one clock, CLOCK; reset is asynchronous and active-high, RESET.
- Byte order is big-endian. Offset 0 maps to bits [31:24]; halfword offset 0 maps to [31:16].
- Write data arrives right-aligned on DDT: byte in [7:0], halfword in [15:0]. Only the addressed lane(s) are updated.
- Read data is returned right-aligned and zero-extended. Sign extension is the master's job.
- FSM:
  - IDLE: MREQ=1 at an edge → latch DAD/WRITE/SIZE/DDT; go to WAIT with counter=WAIT_CYC, or directly to ACK if WAIT_CYC=0.
  - WAIT: decrement the counter each cycle; when it reaches 0, go to ACK. MREQ=0 here aborts to IDLE with no write and no ACK.
  - ACK: ACKD_n=0 for exactly one cycle. RAM write commits on the edge entering ACK. Read data is registered on the same edge and driven on DDT only while in ACK. Next state is DONE.
  - DONE: ACKD_n=1, DDT high-Z; stay until MREQ=0, then go to IDLE. This guarantees at least one idle cycle between accesses; a held MREQ is never double-served.
- Latency: with MREQ rising before edge k, ACKD_n is low during cycle k+WAIT_CYC .. k+WAIT_CYC+1.
- RESET asserted mid-access: immediate IDLE, ACKD_n=1, DDT released. A write is lost unless it already committed on entry to ACK.
- Reserved SIZE=11 behaves exactly as a word access.

Optional Feature:
- Macro: DBUS_ALIGN_CHK_EN.
- Defined:
  - ERR port exists.
  - Access is misaligned if halfword with DAD[0]=1, or word/reserved with DAD[1:0]≠00.
  - Misaligned accesses are still ACKed with normal timing. Writes are suppressed; reads return 32'h0.
  - ERR=1 exactly during the ACK cycle of a misaligned access, else 0.
- Not defined:
  - No ERR port.
  - Low address bits below the access size are ignored (forced alignment). Access proceeds normally.

Test Plan:
- WAIT_CYC=1: word write DAD=0x10, DDT=0xDEADBEEF, then word read DAD=0x10 → ACKD_n low one cycle, 2 cycles after request each time; read DDT=0xDEADBEEF during ACK, high-Z otherwise.
- Byte writes 0x11,0x22,0x33,0x44 to DAD=0x20..0x23, then word read 0x20 → 0x11223344. Halfword read 0x22 → 0x00003344. Byte read 0x21 → 0x00000022.
- WAIT_CYC=0 with MREQ held high for 4 cycles → exactly one ACKD_n low pulse, in the cycle after acceptance. No second ACK until MREQ drops for one cycle.
- WAIT_CYC=3: MREQ deasserted after 1 wait cycle on write DAD=0x30, DDT=0x12345678 → no ACK. A later read of 0x30 returns the prior contents (0x00000000 after a preceding explicit write of 0).
- RESET pulsed during WAIT of a read → ACKD_n=1 and DDT=Z immediately. A fresh request is then served normally.
- With DBUS_ALIGN_CHK_EN: halfword write DAD=0x41, DDT=0xBEEF → ACK with ERR=1, word at 0x40 unchanged. Word read DAD=0x42 → DDT=0x0, ERR=1. Without the macro, the same halfword write updates bytes 0x40–0x41.
